// File: rtl/counter_run_scheduler.sv
// Round-robin scheduler that lends one shared counter to N_REQ requesters for
// timed runs, holding the counter in sync clear whenever no run is active.
module counter_run_scheduler #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   a_rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] len,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       ack,
    output logic                   busy,
    output logic                   cnt_clear,
    input  logic [WIDTH-1:0]       cnt_count,
    input  logic                   cnt_done,
    output logic                   err
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q,  state_d;
    logic [N_REQ-1:0] grant_q,  grant_d;
    logic [IDX_W-1:0] owner_q,  owner_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic             err_q,    err_d;

    logic [WIDTH-1:0] len_slice [N_REQ];
    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] owner_next;
    logic             owner_req;
    logic             run_match;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            len_slice[i] = len[i*WIDTH +: WIDTH];
        end
    end

    // First requesting index at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = IDX_W'((int'(rr_ptr_q) + i) % N_REQ);
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign owner_next = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign owner_req  = req[owner_q];
    // Count starts at 0 in the first RUN cycle, so target-1 marks the last one.
    assign run_match  = (cnt_count == target_q - 1'b1);

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through the
        // case below can leave one unassigned and infer a latch.
        state_d  = state_q;
        grant_d  = grant_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        target_d = target_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d  = N_REQ'(1) << pick_idx;
                    owner_d  = pick_idx;
                    target_d = len_slice[pick_idx];
                    state_d  = (len_slice[pick_idx] == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (run_match) begin
                    state_d = DONE;
                end else if (cnt_done) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (!owner_req) begin
                    grant_d  = '0;
                    rr_ptr_d = owner_next;
                    state_d  = IDLE;
                end
            end
            DONE: begin
                grant_d  = '0;
                rr_ptr_d = owner_next;
                state_d  = IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            target_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            target_q <= target_d;
            err_q    <= err_d;
        end
    end

    // Outputs decode straight from registers so reset clears them without a clock.
    assign grant     = grant_q;
    assign ack       = (state_q == DONE) ? grant_q : '0;
    assign busy      = (state_q != IDLE);
    assign cnt_clear = (state_q != RUN);
    assign err       = err_q;

endmodule

// File: tb/tb_counter_run_scheduler.sv
// Bench for counter_run_scheduler: directed scenarios plus random requests,
// compared each cycle against a transaction-level model of the scheduler.
module tb_counter_run_scheduler;

    localparam int N_REQ = 4;
    localparam int WIDTH = 8;

    logic                   clk   = 1'b0;
    logic                   a_rst = 1'b1;
    logic [N_REQ-1:0]       req   = '0;
    logic [N_REQ*WIDTH-1:0] len   = '0;
    logic                   cnt_done = 1'b0;
    logic [N_REQ-1:0]       grant, ack;
    logic                   busy, cnt_clear, err;
    logic [WIDTH-1:0]       cnt_count;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;
    bit auto_drop = 1'b1;

    // Model: the current run as (owner, start cycle, length); DONE is offset == length.
    bit m_active = 1'b0;
    int m_owner  = 0;
    int m_start  = 0;
    int m_len    = 0;
    int m_rr     = 0;
    bit m_err    = 1'b0;

    int grant_order[$];
    int ack_cycles[$];
    int grant_cycles;
    int ack_pulses;
    int first_grant;
    bit clear_low_seen;
    logic [N_REQ-1:0] prev_grant = '0;

    always #5 clk = ~clk;

    // Behavioural counter: sync clear, otherwise +1 per clock.
    always @(posedge clk) cnt_count <= cnt_clear ? '0 : cnt_count + 1'b1;

    counter_run_scheduler #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .a_rst     (a_rst),
        .req       (req),
        .len       (len),
        .grant     (grant),
        .ack       (ack),
        .busy      (busy),
        .cnt_clear (cnt_clear),
        .cnt_count (cnt_count),
        .cnt_done  (cnt_done),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    function automatic logic [N_REQ-1:0] onehot(input int idx);
        logic [N_REQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Advance the model across one clock edge using the inputs the DUT sampled.
    task automatic model_edge();
        int prev_off;
        if (!a_rst) begin
            m_active = 1'b0;
            m_rr     = 0;
            m_err    = 1'b0;
        end else if (m_active) begin
            prev_off = cycle - 1 - m_start;
            if (prev_off >= m_len) begin
                m_active = 1'b0;
                m_rr     = (m_owner + 1) % N_REQ;
            end else if (prev_off != m_len - 1) begin
                if (cnt_done) begin
                    m_err = 1'b1;
                    m_len = prev_off + 1;
                end else if (!req[m_owner]) begin
                    m_active = 1'b0;
                    m_rr     = (m_owner + 1) % N_REQ;
                end
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                int k;
                k = (m_rr + i) % N_REQ;
                if (!m_active && req[k]) begin
                    m_active = 1'b1;
                    m_owner  = k;
                    m_start  = cycle;
                    m_len    = int'(len[k*WIDTH +: WIDTH]);
                end
            end
        end
    endtask

    task automatic compare_outputs();
        logic [N_REQ-1:0] eg, ea;
        bit eb, ec;
        int off;
        eg = '0; ea = '0; eb = 1'b0; ec = 1'b1;
        if (m_active) begin
            off = cycle - m_start;
            eg  = onehot(m_owner);
            eb  = 1'b1;
            if (off < m_len)  ec = 1'b0;
            if (off == m_len) ea = eg;
            check("cnt_count", 32'(cnt_count), off);
        end
        check("grant",     32'(grant),     32'(eg));
        check("ack",       32'(ack),       32'(ea));
        check("busy",      32'(busy),      32'(eb));
        check("cnt_clear", 32'(cnt_clear), 32'(ec));
        check("err",       32'(err),       32'(m_err));
    endtask

    task automatic observe();
        if (grant != '0) grant_cycles++;
        if (ack != '0) begin
            ack_pulses++;
            ack_cycles.push_back(cycle);
        end
        if (grant != '0 && prev_grant == '0) begin
            for (int i = 0; i < N_REQ; i++) if (grant[i]) grant_order.push_back(i);
            if (first_grant < 0) first_grant = cycle;
        end
        if (!cnt_clear) clear_low_seen = 1'b1;
        prev_grant = grant;
    endtask

    task automatic clear_log();
        grant_order.delete();
        ack_cycles.delete();
        grant_cycles   = 0;
        ack_pulses     = 0;
        first_grant    = -1;
        clear_low_seen = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cycle++;
        model_edge();
        compare_outputs();
        observe();
        // A requester holds req until its ack, then lets go.
        if (auto_drop && m_active && (cycle - m_start == m_len)) req[m_owner] = 1'b0;
    endtask

    task automatic wait_count(input int n);
        int k;
        k = 0;
        while (int'(cnt_count) != n && k < 40) begin
            step();
            k++;
        end
        if (k == 40) check("wait_count", 32'(cnt_count), n);
    endtask

    task automatic set_len(input int i, input int v);
        len[i*WIDTH +: WIDTH] = WIDTH'(v);
    endtask

    initial begin
        int t0;
        clear_log();

        // Power-on reset, outputs checked before any clock edge.
        #1 a_rst = 1'b0;
        #1;
        check("rst_grant", 32'(grant),     0);
        check("rst_ack",   32'(ack),       0);
        check("rst_busy",  32'(busy),      0);
        check("rst_clear", 32'(cnt_clear), 1);
        check("rst_err",   32'(err),       0);
        repeat (3) step();
        a_rst = 1'b1;
        step();

        // Single requester, length 5.
        clear_log();
        req[1] = 1'b1;
        set_len(1, 5);
        t0 = cycle;
        repeat (10) step();
        check("t1_grant_rise", first_grant, t0 + 1);
        check("t1_ack_offset", (ack_cycles.size() > 0) ? ack_cycles[0] - first_grant : -1, 5);
        check("t1_grant_len",  grant_cycles, 6);
        check("t1_ack_pulses", ack_pulses, 1);
        check("t1_idle_clear", 32'(cnt_clear), 1);
        check("t1_idle_count", 32'(cnt_count), 0);

        // Round-robin with all four held, length 3, starting from a fresh reset.
        a_rst = 1'b0;
        step();
        a_rst = 1'b1;
        clear_log();
        auto_drop = 1'b0;
        for (int i = 0; i < N_REQ; i++) set_len(i, 3);
        req = '1;
        repeat (24) step();
        req = '0;
        auto_drop = 1'b1;
        check("rr_grants", grant_order.size(), 5);
        for (int i = 0; i < 5 && i < grant_order.size(); i++)
            check("rr_order", grant_order[i], i % N_REQ);
        for (int i = 1; i < ack_cycles.size(); i++)
            check("rr_spacing", ack_cycles[i] - ack_cycles[i-1], 5);
        repeat (2) step();

        // Zero-length run: grant and ack in the same single cycle, counter never released.
        clear_log();
        set_len(2, 0);
        req[2] = 1'b1;
        repeat (4) step();
        check("z_owner",       (grant_order.size() > 0) ? grant_order[0] : -1, 2);
        check("z_grant_len",   grant_cycles, 1);
        check("z_ack_pulses",  ack_pulses, 1);
        check("z_ack_at_gnt",  (ack_cycles.size() > 0) ? ack_cycles[0] : -1, first_grant);
        check("z_clear_low",   32'(clear_low_seen), 0);

        // Abort: owner 0 drops req at count 4, requester 1 is served next.
        clear_log();
        set_len(0, 10);
        req[0] = 1'b1;
        wait_count(4);
        req[0] = 1'b0;
        req[1] = 1'b1;
        set_len(1, 2);
        step();
        check("ab_idle_grant", 32'(grant), 0);
        check("ab_idle_busy",  32'(busy),  0);
        step();
        check("ab_next_grant", 32'(grant), 32'(4'b0010));
        repeat (5) step();
        check("ab_ack_pulses", ack_pulses, 1);

        // Reset in the middle of a run.
        clear_log();
        set_len(3, 10);
        req[3] = 1'b1;
        wait_count(6);
        a_rst = 1'b0;
        #1;
        check("mr_grant", 32'(grant),     0);
        check("mr_busy",  32'(busy),      0);
        check("mr_ack",   32'(ack),       0);
        check("mr_clear", 32'(cnt_clear), 1);
        set_len(0, 2);
        set_len(3, 2);
        req = 4'b1001;
        repeat (2) step();
        a_rst = 1'b1;
        clear_log();
        step();
        check("mr_restart", 32'(grant), 32'(4'b0001));
        repeat (10) step();
        check("mr_ack_pulses", ack_pulses, 2);
        check("mr_second", (grant_order.size() > 1) ? grant_order[1] : -1, 3);

        // Early done at count 2 of an 8-cycle run.
        clear_log();
        set_len(2, 8);
        req[2] = 1'b1;
        wait_count(2);
        cnt_done = 1'b1;
        step();
        cnt_done = 1'b0;
        check("ed_err", 32'(err), 1);
        check("ed_ack", 32'(ack), 32'(4'b0100));
        repeat (2) step();
        set_len(1, 3);
        req[1] = 1'b1;
        repeat (8) step();
        check("ed_err_sticky", 32'(err), 1);
        check("ed_ack_pulses", ack_pulses, 2);
        check("ed_next_owner", (grant_order.size() > 1) ? grant_order[1] : -1, 1);

        // Random requests and lengths; lengths also change under an active run.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N_REQ; i++) begin
                set_len(i, int'($urandom_range(0, 6)));
                if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
            end
            step();
        end
        repeat (60) step();
        check("drain_busy", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
